// File: rtl/fifo_access_sched.sv
// Access scheduler in front of a shared single-port-per-cycle FIFO: round-robin
// among NREQ writers, with a bounded-starvation rule that lets the reader in.

module fifo_access_sched_lane #(
   parameter int DW = 8
) (
   input  logic          gnt,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] gated
);
   assign gated = {DW{gnt}} & data;
endmodule

module fifo_access_sched #(
   parameter int NREQ          = 4,
   parameter int DW            = 8,
   parameter int RD_STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    wr_req,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]    wr_gnt,
   input  logic               rd_req,
   output logic               rd_gnt,
   output logic               rd_valid,
   output logic [DW-1:0]      rd_data,
   output logic               fifo_we,
   output logic               fifo_re,
   output logic [DW-1:0]      fifo_wdata,
   input  logic [DW-1:0]      fifo_rdata,
   input  logic               fifo_full,
   input  logic               fifo_empty
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = (RD_STARVE_MAX > 0) ? $clog2(RD_STARVE_MAX + 1) : 1;
   localparam logic [SW-1:0] SMAX = SW'(RD_STARVE_MAX);

   logic [PW-1:0]             rr_ptr;
   logic [PW-1:0]             wsel;
   logic                      wfound;
   logic [SW-1:0]             starve_cnt;
   logic                      wr_elig, rd_elig, wr_win, rd_win;
   logic [NREQ-1:0][DW-1:0]   lane_wd;

   // Rotating search: first requester strictly after the last granted port.
   always_comb begin
      int k;
      wsel   = '0;
      wfound = 1'b0;
      k      = 0;
      for (int i = 1; i <= NREQ; i++) begin
         k = int'(rr_ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         if (!wfound && wr_req[PW'(k)]) begin
            wfound = 1'b1;
            wsel   = PW'(k);
         end
      end
   end

   assign wr_elig = (|wr_req) && !fifo_full;
   assign rd_elig = rd_req && !fifo_empty;
   // rst gates the strobes so nothing reaches the FIFO while held in reset.
   assign rd_win  = rst && rd_elig && (!wr_elig || (starve_cnt == SMAX));
   assign wr_win  = rst && wr_elig && !rd_win;

   assign rd_gnt  = rd_win;
   assign fifo_re = rd_win;
   assign fifo_we = wr_win;
   assign rd_data = fifo_rdata;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign wr_gnt[g] = wr_win && (wsel == PW'(g));
      fifo_access_sched_lane #(.DW(DW)) u_lane (
         .gnt   (wr_gnt[g]),
         .data  (wr_data[g*DW +: DW]),
         .gated (lane_wd[g])
      );
   end

   always_comb begin
      fifo_wdata = '0;
      for (int i = 0; i < NREQ; i++) fifo_wdata = fifo_wdata | lane_wd[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr     <= PW'(NREQ - 1);
         starve_cnt <= '0;
         rd_valid   <= 1'b0;
      end else begin
         if (wr_win) rr_ptr <= wsel;
         if (!rd_elig || rd_win)
            starve_cnt <= '0;
         else if (wr_win && (starve_cnt != SMAX))
            starve_cnt <= starve_cnt + 1'b1;
         rd_valid <= rd_win;
      end
   end
endmodule

// File: tb/tb_fifo_access_sched.sv
// Bench for fifo_access_sched: two instances (starve limit 4 and 0) share one
// stimulus stream and are checked every cycle against a behavioural model.

module tb_fifo_access_sched;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   wr_req;
   logic [N*W-1:0] wr_data;
   logic           rd_req;
   logic [W-1:0]   fifo_rdata;
   logic           fifo_full, fifo_empty;

   logic [N-1:0] wg_a, wg_b;
   logic         rg_a, rg_b, rv_a, rv_b, we_a, we_b, re_a, re_b;
   logic [W-1:0] rdd_a, rdd_b, wd_a, wd_b;

   fifo_access_sched #(.NREQ(N), .DW(W), .RD_STARVE_MAX(4)) dut_a (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wg_a),
      .rd_req(rd_req), .rd_gnt(rg_a), .rd_valid(rv_a), .rd_data(rdd_a),
      .fifo_we(we_a), .fifo_re(re_a), .fifo_wdata(wd_a), .fifo_rdata(fifo_rdata),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty));

   fifo_access_sched #(.NREQ(N), .DW(W), .RD_STARVE_MAX(0)) dut_b (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wg_b),
      .rd_req(rd_req), .rd_gnt(rg_b), .rd_valid(rv_b), .rd_data(rdd_b),
      .fifo_we(we_b), .fifo_re(re_b), .fifo_wdata(wd_b), .fifo_rdata(fifo_rdata),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty));

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: "last" is the most recently granted writer, "starve" counts
   // write grants taken while a read was waiting.
   function automatic void model(input int last, input int starve, input int maxs,
                                 output logic [N-1:0] wg, output logic rg,
                                 output logic [W-1:0] wd, output int gi, output logic rel);
      logic wel, found;
      int p;
      wel = (wr_req != 0) && !fifo_full;
      rel = rd_req && !fifo_empty;
      rg  = rst && rel && (!wel || starve == maxs);
      wg  = '0; wd = '0; gi = -1; found = 1'b0;
      if (rst && wel && !rg) begin
         for (int j = 1; j <= N; j++) begin
            p = (last + j) % N;
            if (!found && wr_req[p]) begin
               found = 1'b1;
               gi = p;
               wg = N'(1) << p;
               wd = wr_data[p*W +: W];
            end
         end
      end
   endfunction

   int last_a, st_a, last_b, st_b;
   logic rv_ea, rv_eb;
   logic [N-1:0] ug; logic ur, urel; logic [W-1:0] ud; int ugi;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_a <= N-1; st_a <= 0; rv_ea <= 1'b0;
         last_b <= N-1; st_b <= 0; rv_eb <= 1'b0;
      end else begin
         model(last_a, st_a, 4, ug, ur, ud, ugi, urel);
         if (ugi >= 0) last_a <= ugi;
         if (!urel || ur) st_a <= 0;
         else if (ugi >= 0 && st_a < 4) st_a <= st_a + 1;
         rv_ea <= ur;
         model(last_b, st_b, 0, ug, ur, ud, ugi, urel);
         if (ugi >= 0) last_b <= ugi;
         st_b  <= 0;
         rv_eb <= ur;
      end
   end

   logic [N-1:0] cg; logic cr, crel; logic [W-1:0] cd; int cgi;

   always @(negedge clk) begin
      model(last_a, st_a, 4, cg, cr, cd, cgi, crel);
      chk("a.wr_gnt", 32'(wg_a), 32'(cg));
      chk("a.rd_gnt", 32'(rg_a), 32'(cr));
      chk("a.fifo_we", 32'(we_a), 32'(|cg));
      chk("a.fifo_re", 32'(re_a), 32'(cr));
      chk("a.fifo_wdata", 32'(wd_a), 32'(cd));
      chk("a.rd_valid", 32'(rv_a), 32'(rv_ea));
      if (rv_ea) chk("a.rd_data", 32'(rdd_a), 32'(fifo_rdata));
      model(last_b, st_b, 0, cg, cr, cd, cgi, crel);
      chk("b.wr_gnt", 32'(wg_b), 32'(cg));
      chk("b.rd_gnt", 32'(rg_b), 32'(cr));
      chk("b.fifo_we", 32'(we_b), 32'(|cg));
      chk("b.fifo_re", 32'(re_b), 32'(cr));
      chk("b.fifo_wdata", 32'(wd_b), 32'(cd));
      chk("b.rd_valid", 32'(rv_b), 32'(rv_eb));
      if (rv_eb) chk("b.rd_data", 32'(rdd_b), 32'(fifo_rdata));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rrseq [8];
   logic [3:0] spseq [3];

   initial begin
      rrseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      spseq = '{4'b0010, 4'b1000, 4'b0010};
      wr_req = '0; wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
      rd_req = 1'b0; fifo_rdata = '0; fifo_full = 1'b0; fifo_empty = 1'b0;

      // reset: requests present but everything held at zero
      #2 wr_req = 4'b1111;
      #1;
      chk("rst.wr_gnt", 32'(wg_a), 0);
      chk("rst.fifo_we", 32'(we_a), 0);
      chk("rst.fifo_wdata", 32'(wd_a), 0);
      chk("rst.rd_valid", 32'(rv_a), 0);
      chk("rst.rd_gnt", 32'(rg_a), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // full round robin, port 0 first
      for (int k = 0; k < 8; k++) begin
         #2;
         chk("rr.gnt", 32'(wg_a), 32'(rrseq[k]));
         chk("rr.wdata", 32'(wd_a), 32'(8'h11 * ((k % 4) + 1)));
         tick();
      end

      // sparse round robin after port 3 was last
      wr_req = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #2 chk("sparse.gnt", 32'(wg_a), 32'(spseq[k]));
         tick();
      end

      // starvation bound: 4 writes then 1 read
      wr_req = 4'b0100; rd_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         fifo_rdata = W'($urandom);
         #2;
         chk("starve.wr_gnt", 32'(wg_a), (k % 5 == 4) ? 0 : 4);
         chk("starve.rd_gnt", 32'(rg_a), (k % 5 == 4) ? 1 : 0);
         if (k == 5) chk("starve.rd_valid", 32'(rv_a), 1);
         tick();
      end

      // full: reads only, round-robin pointer frozen at port 2
      fifo_full = 1'b1; wr_req = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("full.rd_gnt", 32'(rg_a), 1);
         chk("full.wr_gnt", 32'(wg_a), 0);
         tick();
      end
      fifo_full = 1'b0; rd_req = 1'b0;
      #2 chk("full.rr_frozen", 32'(wg_a), 32'(4'b1000));
      tick();

      // empty: nothing granted, no rd_valid
      fifo_empty = 1'b1; wr_req = '0; rd_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("empty.rd_gnt", 32'(rg_a), 0);
         chk("empty.wr_gnt", 32'(wg_a), 0);
         chk("empty.rd_valid", 32'(rv_a), 0);
         tick();
      end

      // reads always win when the limit is 0
      fifo_empty = 1'b0; wr_req = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("rdpri.rd_gnt", 32'(rg_b), 1);
         chk("rdpri.wr_gnt", 32'(wg_b), 0);
         tick();
      end
      rd_req = 1'b0;
      #2 chk("rdpri.release", 32'(wg_b), 32'(4'b0001));
      tick();

      // randomized traffic, occasional reset pulses
      for (int k = 0; k < 2000; k++) begin
         wr_req     = N'($urandom);
         wr_data    = $urandom;
         rd_req     = ($urandom_range(0, 3) != 0);
         fifo_full  = ($urandom_range(0, 7) == 0);
         fifo_empty = ($urandom_range(0, 7) == 0);
         fifo_rdata = W'($urandom);
         rst        = ($urandom_range(0, 63) != 0);
         tick();
      end
      rst = 1'b1; fifo_full = 1'b0; fifo_empty = 1'b0;
      wr_req = '0; rd_req = 1'b1;
      tick();

      // asynchronous reset during a write grant with rd_valid pending
      rd_req = 1'b0; wr_req = 4'b0001;
      #2;
      chk("arst.pre_gnt", 32'(wg_a), 1);
      chk("arst.pre_valid", 32'(rv_a), 1);
      rst = 1'b0;
      #1;
      chk("arst.wr_gnt", 32'(wg_a), 0);
      chk("arst.fifo_we", 32'(we_a), 0);
      chk("arst.rd_valid", 32'(rv_a), 0);
      chk("arst.fifo_wdata", 32'(wd_a), 0);
      tick();
      tick();
      rst = 1'b1; wr_req = 4'b1111;
      #2 chk("arst.first_port0", 32'(wg_a), 32'(4'b0001));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
